// File: rtl/capture_update_chain.sv
// Capture/shift/update scan chain with shadow register and sticky errors.
// Optional update length check enabled by CAPTURE_CHAIN_LENCHK_EN.
module capture_update_chain #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] UPDATE_RESET = '0,
  localparam int CW = $clog2(WIDTH + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_chainIn_shift,
  input  logic             io_chainIn_data,
  input  logic             io_chainIn_capture,
  input  logic             io_chainIn_update,
  input  logic [WIDTH-1:0] io_capture_value,
  input  logic             io_error_clear,
  output logic             io_chainOut_data,
  output logic [WIDTH-1:0] io_update_bits,
  output logic             io_update_valid,
  output logic [CW-1:0]    io_shift_count,
  output logic             io_ctl_error,
  output logic             io_len_error
);

  logic [WIDTH-1:0] r_chain;
  logic [WIDTH-1:0] r_shadow;
  logic [CW-1:0]    r_cnt;
  logic             r_valid;
  logic             r_ctl_err;

  logic [1:0]       w_n_strb;
  logic             w_illegal;
  logic             w_cap;
  logic             w_shift;
  logic             w_upd;
  logic             w_len_ok;
  logic             w_upd_ok;
  logic [WIDTH-1:0] w_chain_nxt;
  logic [CW-1:0]    w_cnt_nxt;

  always_comb begin
    w_n_strb = {1'b0, io_chainIn_capture}
             + {1'b0, io_chainIn_shift}
             + {1'b0, io_chainIn_update};
    w_illegal = (w_n_strb > 2'd1);
    w_cap   = io_chainIn_capture & ~w_illegal;
    w_shift = io_chainIn_shift & ~w_illegal;
    w_upd   = io_chainIn_update & ~w_illegal;
  end

`ifdef CAPTURE_CHAIN_LENCHK_EN
  localparam logic [CW-1:0] LEN = CW'(WIDTH);

  logic r_len_err;
  logic w_upd_rej;

  assign w_len_ok  = (r_cnt == LEN);
  assign w_upd_rej = w_upd & ~w_len_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_upd_rej | (r_len_err & ~io_error_clear);
    end
  end

  assign io_len_error = r_len_err;
`else
  assign w_len_ok     = 1'b1;
  assign io_len_error = 1'b0;
`endif

  assign w_upd_ok = w_upd & w_len_ok;

  // Strobes are one-hot after illegal masking.
  always_comb begin
    w_chain_nxt = r_chain;
    w_cnt_nxt   = r_cnt;
    unique case (1'b1)
      w_cap: begin
        w_chain_nxt = io_capture_value;
        w_cnt_nxt   = '0;
      end
      w_shift: begin
        w_chain_nxt = {io_chainIn_data, r_chain[WIDTH-1:1]};
        if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_chain   <= '0;
      r_cnt     <= '0;
      r_shadow  <= UPDATE_RESET;
      r_valid   <= 1'b0;
      r_ctl_err <= 1'b0;
    end else begin
      r_chain   <= w_chain_nxt;
      r_cnt     <= w_cnt_nxt;
      r_valid   <= w_upd_ok;
      r_ctl_err <= w_illegal | (r_ctl_err & ~io_error_clear);
      if (w_upd_ok) begin
        r_shadow <= r_chain;
      end
    end
  end

  assign io_chainOut_data = r_chain[0];
  assign io_update_bits   = r_shadow;
  assign io_update_valid  = r_valid;
  assign io_shift_count   = r_cnt;
  assign io_ctl_error     = r_ctl_err;

endmodule
